alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu.sv | 85 ++++++++
 rtl/alu_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcodes, flag bit positions and arbiter state type
//                for the alu / alu_arbiter pair.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Opcodes carried on reqi_sel
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  // Bit positions inside the 5-bit flag vector {carry, sign, ovf, parity, zero}
  localparam int FLG_ZERO   = 0;
  localparam int FLG_PARITY = 1;
  localparam int FLG_OVF    = 2;
  localparam int FLG_SIGN   = 3;
  localparam int FLG_CARRY  = 4;

  // Arbiter FSM states, explicitly 2 bits wide
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : 4-bit signed combinational ALU (add/sub/mul/div) with
//                {carry, sign, overflow, parity, zero} flags. Divide by zero
//                yields 0 with overflow set instead of an undefined value.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] sel,
  output logic [3:0] out,
  output logic [4:0] flags
);

  logic [4:0]        w_sum;
  logic [3:0]        w_diff;
  logic signed [7:0] w_a8;
  logic signed [7:0] w_b8;
  logic signed [7:0] w_prod;
  logic signed [4:0] w_a5;
  logic signed [4:0] w_b5;
  logic signed [4:0] w_quot;
  logic [3:0]        w_out;
  logic              w_carry;
  logic              w_ovf;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = a - b;
  assign w_a8   = {{4{a[3]}}, a};
  assign w_b8   = {{4{b[3]}}, b};
  assign w_prod = w_a8 * w_b8;
  // One extra bit so -8 / -1 = +8 is representable and detectable as overflow
  assign w_a5   = {a[3], a};
  assign w_b5   = {b[3], b};
  assign w_quot = (b == 4'd0) ? 5'sd0 : (w_a5 / w_b5);

  // Select the result and the opcode-specific carry/overflow
  always_comb begin
    w_out   = 4'd0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (sel)
      OP_ADD: begin
        w_out   = w_sum[3:0];
        w_carry = w_sum[4];
        w_ovf   = (a[3] == b[3]) && (w_sum[3] != a[3]);
      end
      OP_SUB: begin
        w_out   = w_diff;
        w_carry = ($signed(a) < $signed(b));
        w_ovf   = (a[3] != b[3]) && (w_diff[3] != a[3]);
      end
      OP_MUL: begin
        w_out   = w_prod[3:0];
      end
      default: begin
        if (b == 4'd0) begin
          w_out = 4'd0;
          w_ovf = 1'b1;
        end else begin
          w_out = w_quot[3:0];
          w_ovf = (w_quot[4] != w_quot[3]);
        end
      end
    endcase
  end

  assign out = w_out;

  // Common flags derived from the final 4-bit result; parity is even-parity
  always_comb begin
    flags             = 5'd0;
    flags[FLG_CARRY]  = w_carry;
    flags[FLG_SIGN]   = w_out[3];
    flags[FLG_OVF]    = w_ovf;
    flags[FLG_PARITY] = ~^w_out;
    flags[FLG_ZERO]   = (w_out == 4'd0);
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-requester round-robin front end for a single shared alu.
//                IDLE grants one request, EXEC registers the result, RESP
//                holds it until the consumer accepts it.
//                Optional macro ALU_ARBITER_STATS_EN adds saturating grant
//                and divide-by-zero counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int STAT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req0_sel,
  input  logic [1:0] req1_sel,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_out,
  output logic [4:0] rsp_flags,
  output logic       busy
`ifdef ALU_ARBITER_STATS_EN
  ,
  output logic [STAT_W-1:0] grant0_cnt,
  output logic [STAT_W-1:0] grant1_cnt,
  output logic [STAT_W-1:0] divz_cnt
`endif
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_prio;       // 0 favours req0, 1 favours req1
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [1:0] r_sel;
  logic       r_id;
  logic       r_rsp_id;
  logic [3:0] r_rsp_out;
  logic [4:0] r_rsp_flags;

  logic       w_any;
  logic       w_gid;
  logic       w_take;
  logic [3:0] w_alu_out;
  logic [4:0] w_alu_flags;

  // Lone requester wins outright; under contention the pointer decides
  assign w_any  = req0_valid | req1_valid;
  assign w_gid  = (req0_valid && req1_valid) ? r_prio : req1_valid;
  assign w_take = !rst && (r_state == ST_IDLE) && w_any;

  alu u_alu (
    .a     (r_a),
    .b     (r_b),
    .sel   (r_sel),
    .out   (w_alu_out),
    .flags (w_alu_flags)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any)     w_state_nxt = ST_EXEC;
      ST_EXEC:                w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs; all forced low while reset is asserted
  always_comb begin
    req0_ready = w_take && !w_gid;
    req1_ready = w_take &&  w_gid;
    busy       = !rst && (r_state != ST_IDLE);
    rsp_valid  = !rst && (r_state == ST_RESP);
  end

  // Operand capture at grant, result capture at the end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio      <= 1'b0;
      r_a         <= 4'd0;
      r_b         <= 4'd0;
      r_sel       <= 2'd0;
      r_id        <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_out   <= 4'd0;
      r_rsp_flags <= 5'd0;
    end else begin
      if (w_take) begin
        r_a    <= w_gid ? req1_a   : req0_a;
        r_b    <= w_gid ? req1_b   : req0_b;
        r_sel  <= w_gid ? req1_sel : req0_sel;
        r_id   <= w_gid;
        r_prio <= ~w_gid;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_id    <= r_id;
        r_rsp_out   <= w_alu_out;
        r_rsp_flags <= w_alu_flags;
      end
    end
  end

  assign rsp_id    = r_rsp_id;
  assign rsp_out   = r_rsp_out;
  assign rsp_flags = r_rsp_flags;

`ifdef ALU_ARBITER_STATS_EN
  logic [STAT_W-1:0] r_g0_cnt;
  logic [STAT_W-1:0] r_g1_cnt;
  logic [STAT_W-1:0] r_dz_cnt;
  logic              w_divz;

  assign w_divz = w_take && ((w_gid ? req1_sel : req0_sel) == OP_DIV)
                         && ((w_gid ? req1_b   : req0_b)   == 4'd0);

  // Saturating statistics counters, sampled at grant time
  always_ff @(posedge clk) begin
    if (rst) begin
      r_g0_cnt <= '0;
      r_g1_cnt <= '0;
      r_dz_cnt <= '0;
    end else begin
      if (w_take && !w_gid && (r_g0_cnt != '1)) r_g0_cnt <= r_g0_cnt + STAT_W'(1);
      if (w_take &&  w_gid && (r_g1_cnt != '1)) r_g1_cnt <= r_g1_cnt + STAT_W'(1);
      if (w_divz && (r_dz_cnt != '1))           r_dz_cnt <= r_dz_cnt + STAT_W'(1);
    end
  end

  assign grant0_cnt = r_g0_cnt;
  assign grant1_cnt = r_g1_cnt;
  assign divz_cnt   = r_dz_cnt;
`endif

endmodule
`default_nettype wire
